fpga_selftest_top: RTL and testbench

FPGA-level self-test top for the image pipeline. When enabled, it generates a deterministic pixel test pattern and pushes it through an internal FIFO. The consumer side is throttled by an LFSR. A checker regenerates the expected stream and compares every pixel. At the end it reports a single done flag and a sticky error flag to board pins or LEDs.

---
 rtl/fpga_selftest_top.sv | 146 ++++++++++++++
 tb/tb_fpga_selftest_top.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fpga_selftest_top.sv
// Board-level self-test: a pattern generator feeds a FIFO, an LFSR-throttled consumer drains it,
// and a checker regenerates the stream. The results are sticky done/error flags.
module fpga_selftest_top #(
    parameter int unsigned IMG_WIDTH      = 16,
    parameter int unsigned IMG_HEIGHT     = 8,
    parameter int unsigned NUM_FRAMES     = 2,
    parameter int unsigned PIX_W          = 10,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT        = 4096,
    parameter int          INJECT_ERR_IDX = -1,
    parameter bit          FORCE_STALL    = 1'b0
) (
    input  logic clk_in1_p_0,
    input  logic clk_in1_n_0,
    input  logic reset_i,
    input  logic enable_i_0,
    output logic done_o_0,
    output logic error_0
);
    localparam int unsigned XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned FW = $clog2(NUM_FRAMES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned EW = PIX_W + 2;
    localparam int unsigned LAST_IDX = IMG_WIDTH * IMG_HEIGHT * NUM_FRAMES - 1;

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e        state_q;
    logic [XW-1:0] gen_x_q, chk_x_q;
    logic [YW-1:0] gen_y_q, chk_y_q;
    logic [FW-1:0] gen_f_q, chk_f_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [7:0]    lfsr_q;
    logic [TW-1:0] tmo_q;
    logic          done_q, error_q;

    logic          full, empty, push, pop, inject, mismatch, last_pop, fb;
    logic [EW-1:0] gen_entry, rd_entry, exp_entry;
    logic          unused_clk_n;

    assign unused_clk_n = clk_in1_n_0;

    function automatic logic [31:0] lin_idx(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                            input logic [FW-1:0] f);
        return 32'(f) * IMG_WIDTH * IMG_HEIGHT + 32'(y) * IMG_WIDTH + 32'(x);
    endfunction

    // Entry layout: {sof, eol, pixel}
    function automatic logic [EW-1:0] entry(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                            input logic [FW-1:0] f);
        logic [31:0] sum;
        sum = 32'(x) + 32'd3 * 32'(y) + 32'd7 * 32'(f);
        return {(x == '0) && (y == '0), x == XW'(IMG_WIDTH - 1), sum[PIX_W-1:0]};
    endfunction

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign push      = (state_q == StRun) && (gen_f_q < FW'(NUM_FRAMES)) && !full;
    assign pop       = (state_q == StRun) && lfsr_q[0] && !empty && !FORCE_STALL;
    assign inject    = (INJECT_ERR_IDX >= 0) && (lin_idx(gen_x_q, gen_y_q, gen_f_q)
                                                 == 32'(INJECT_ERR_IDX));
    assign gen_entry = entry(gen_x_q, gen_y_q, gen_f_q) ^ {{(EW-1){1'b0}}, inject};
    assign rd_entry  = mem[rd_ptr_q[AW-1:0]];
    assign exp_entry = entry(chk_x_q, chk_y_q, chk_f_q);
    assign mismatch  = pop && (rd_entry != exp_entry);
    assign last_pop  = pop && (lin_idx(chk_x_q, chk_y_q, chk_f_q) == LAST_IDX);
    assign fb        = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_ff @(posedge clk_in1_p_0) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= gen_entry;
    end

    always_ff @(posedge clk_in1_p_0) begin
        if (reset_i) begin
            state_q  <= StIdle;
            gen_x_q  <= '0;
            gen_y_q  <= '0;
            gen_f_q  <= '0;
            chk_x_q  <= '0;
            chk_y_q  <= '0;
            chk_f_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lfsr_q   <= 8'hA5;
            tmo_q    <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                if (gen_x_q == XW'(IMG_WIDTH - 1)) begin
                    gen_x_q <= '0;
                    if (gen_y_q == YW'(IMG_HEIGHT - 1)) begin
                        gen_y_q <= '0;
                        gen_f_q <= gen_f_q + FW'(1);
                    end else begin
                        gen_y_q <= gen_y_q + YW'(1);
                    end
                end else begin
                    gen_x_q <= gen_x_q + XW'(1);
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                if (chk_x_q == XW'(IMG_WIDTH - 1)) begin
                    chk_x_q <= '0;
                    if (chk_y_q == YW'(IMG_HEIGHT - 1)) begin
                        chk_y_q <= '0;
                        chk_f_q <= chk_f_q + FW'(1);
                    end else begin
                        chk_y_q <= chk_y_q + YW'(1);
                    end
                end else begin
                    chk_x_q <= chk_x_q + XW'(1);
                end
            end
            if (mismatch) error_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (enable_i_0) state_q <= StRun;
                end
                StRun: begin
                    lfsr_q <= {lfsr_q[6:0], fb};
                    tmo_q  <= pop ? '0 : tmo_q + TW'(1);
                    if (last_pop) begin
                        state_q <= StFinish;
                        done_q  <= 1'b1;
                    end else if (!pop && (tmo_q == TW'(TIMEOUT))) begin
                        state_q <= StFinish;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end
                end
                StFinish: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign done_o_0 = done_q;
    assign error_0  = error_q;
endmodule

// File: tb/tb_fpga_selftest_top.sv
// Directed bench: default run, idle hold, injected error, mid-run reset, enable drop, timeout.
module tb_fpga_selftest_top;
    logic clk = 1'b0, clk_n, rst = 1'b1, en = 1'b0;
    logic done_a, err_a, done_b, err_b, done_c, err_c;
    int   n_checks = 0, n_errs = 0;
    int   cyc, lat, err_cyc, bad;

    always #5 clk = ~clk;
    assign clk_n = ~clk;

    fpga_selftest_top dut_a (
        .clk_in1_p_0(clk), .clk_in1_n_0(clk_n), .reset_i(rst), .enable_i_0(en),
        .done_o_0(done_a), .error_0(err_a)
    );
    fpga_selftest_top #(.INJECT_ERR_IDX(37)) dut_b (
        .clk_in1_p_0(clk), .clk_in1_n_0(clk_n), .reset_i(rst), .enable_i_0(en),
        .done_o_0(done_b), .error_0(err_b)
    );
    fpga_selftest_top #(.TIMEOUT(64), .FORCE_STALL(1'b1)) dut_c (
        .clk_in1_p_0(clk), .clk_in1_n_0(clk_n), .reset_i(rst), .enable_i_0(en),
        .done_o_0(done_c), .error_0(err_c)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Counts edges from the enable-sampling edge (=1) until done is seen, capped at 1200.
    task automatic wait_done_a(output int n);
        n = 0;
        while (n < 1200 && !done_a) begin
            tick();
            n++;
        end
    endtask

    // Reference: edges from the enable-sampling edge until done is visible, default config.
    function automatic int model_latency();
        logic [7:0] l;
        int occ, gen, pops;
        bit do_pop, do_push;
        l = 8'hA5; occ = 0; gen = 0; pops = 0;
        for (int n = 1; n < 5000; n++) begin
            do_pop  = l[0] && (occ > 0);
            do_push = (gen < 256) && (occ < 8);
            if (do_push) begin occ++; gen++; end
            if (do_pop) begin occ--; pops++; end
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
            if (do_pop && pops == 256) return n + 1;
        end
        return -1;
    endfunction

    initial begin
        lat = model_latency();

        // Default run
        do_reset();
        check("rst_done_a", done_a, 0);
        check("rst_err_a", err_a, 0);
        check("rst_done_b", done_b, 0);
        check("rst_err_b", err_b, 0);
        check("rst_done_c", done_c, 0);
        check("rst_err_c", err_c, 0);
        en = 1'b1;
        wait_done_a(cyc);
        check("p1_done", done_a, 1);
        check("p1_err", err_a, 0);
        check("p1_lat_range", int'(cyc >= 258 && cyc <= 1200), 1);
        check("p1_lat_exact", cyc, lat);
        bad = 0;
        repeat (20) begin
            tick();
            if (!done_a || err_a) bad++;
        end
        check("p1_done_hold", bad, 0);

        // Enable held low
        do_reset();
        bad = 0;
        repeat (100) begin
            tick();
            if (done_a || err_a || done_b || err_b || done_c || err_c) bad++;
        end
        check("p2_idle_quiet", bad, 0);

        // Injected error at index 37
        do_reset();
        en = 1'b1;
        cyc = 0;
        err_cyc = -1;
        while (cyc < 1200 && !done_b) begin
            tick();
            cyc++;
            if (err_b && err_cyc < 0) err_cyc = cyc;
        end
        check("p3_done", done_b, 1);
        check("p3_err", err_b, 1);
        check("p3_err_before_done", int'(err_cyc >= 0 && err_cyc <= cyc), 1);
        check("p3_err_not_early", int'(err_cyc >= 40), 1);
        check("p3_lat_exact", cyc, lat);

        // Reset mid-run, then a clean rerun
        do_reset();
        en = 1'b1;
        repeat (100) tick();
        check("p4_running", done_a, 0);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        check("p4_rst_done", done_a, 0);
        check("p4_rst_err", err_a, 0);
        rst = 1'b0;
        tick();
        tick();
        check("p4_idle_after_rst", done_a, 0);
        en = 1'b1;
        wait_done_a(cyc);
        check("p4_done", done_a, 1);
        check("p4_err", err_a, 0);
        check("p4_lat_exact", cyc, lat);

        // Enable dropped shortly after start
        do_reset();
        en = 1'b1;
        repeat (5) tick();
        en = 1'b0;
        wait_done_a(cyc);
        check("p5_done", done_a, 1);
        check("p5_err", err_a, 0);
        check("p5_lat_exact", cyc + 5, lat);

        // Stalled consumer, timeout 64: no pop ever, so the count starts at RUN entry
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (64) tick();
        check("p6_done_before", done_c, 0);
        check("p6_err_before", err_c, 0);
        tick();
        check("p6_done_at", done_c, 1);
        check("p6_err_at", err_c, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
